// File: rtl/morse_stream_decoder_if.sv
// morse_stream_decoder_if: decoded ASCII character stream with valid/ready handshake
interface morse_stream_decoder_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/morse_stream_decoder.sv
// morse_stream_decoder: CW level / manual strobes -> dots, dashes, gaps -> ASCII characters in a FIFO
module morse_stream_decoder #(
  parameter int UNIT_CYCLES   = 1000,
  parameter int GLITCH_CYCLES = 4,
  parameter int MAX_SYMS      = 6,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx_cw,
  input  logic                          dot_inp,
  input  logic                          dash_inp,
  input  logic                          char_space_inp,
  input  logic                          word_space_inp,
  morse_stream_decoder_if.master        m_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          busy
);
  localparam int SAT = 8 * UNIT_CYCLES;
  localparam int CW  = $clog2(SAT + 1);
  localparam int NW  = $clog2(MAX_SYMS + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] C_SAT = CW'(SAT);
  localparam logic [CW-1:0] C_GL  = CW'(GLITCH_CYCLES);
  localparam logic [CW-1:0] C_DOT = CW'(2 * UNIT_CYCLES);
  localparam logic [CW-1:0] C_CH  = CW'(3 * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] C_WD  = CW'(7 * UNIT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, EMIT_CHAR, EMIT_SPACE} state_t;

  logic [1:0]          r_sync;
  logic                r_cw_d;
  logic [CW-1:0]       r_mark, r_space;
  logic [MAX_SYMS-1:0] r_pat;
  logic [NW-1:0]       r_cnt;
  logic                r_too_long;
  state_t              r_state, w_next;
  logic [7:0]          r_code;
  logic                r_sp_pend, r_any, r_last_sp;
  logic [7:0]          r_mem [FIFO_DEPTH];
  logic [AW-1:0]       r_rd, r_wr;
  logic [AW:0]         r_level;
  logic                r_ovf;

  logic w_cw, w_fall, w_acc, w_quiet;
  logic w_rx_dot, w_rx_dash, w_rx_char, w_rx_word, w_man;
  logic w_ev_dot, w_ev_dash, w_ev_char, w_ev_word, w_sym;
  logic w_bad, w_take, w_char_go, w_space_go;
  logic w_push, w_last_sp, w_any, w_valid, w_pop, w_full, w_wr;
  logic [7:0] w_code, w_push_data;

  function automatic logic [7:0] f_decode(input logic [7:0] k);
    case (k)
      8'b010_00001: return 8'h41;
      8'b100_01000: return 8'h42;
      8'b100_01010: return 8'h43;
      8'b011_00100: return 8'h44;
      8'b001_00000: return 8'h45;
      8'b100_00010: return 8'h46;
      8'b011_00110: return 8'h47;
      8'b100_00000: return 8'h48;
      8'b010_00000: return 8'h49;
      8'b100_00111: return 8'h4A;
      8'b011_00101: return 8'h4B;
      8'b100_00100: return 8'h4C;
      8'b010_00011: return 8'h4D;
      8'b010_00010: return 8'h4E;
      8'b011_00111: return 8'h4F;
      8'b100_00110: return 8'h50;
      8'b100_01101: return 8'h51;
      8'b011_00010: return 8'h52;
      8'b011_00000: return 8'h53;
      8'b001_00001: return 8'h54;
      8'b011_00001: return 8'h55;
      8'b100_00001: return 8'h56;
      8'b011_00011: return 8'h57;
      8'b100_01001: return 8'h58;
      8'b100_01011: return 8'h59;
      8'b100_01100: return 8'h5A;
      8'b101_11111: return 8'h30;
      8'b101_01111: return 8'h31;
      8'b101_00111: return 8'h32;
      8'b101_00011: return 8'h33;
      8'b101_00001: return 8'h34;
      8'b101_00000: return 8'h35;
      8'b101_10000: return 8'h36;
      8'b101_11000: return 8'h37;
      8'b101_11100: return 8'h38;
      8'b101_11110: return 8'h39;
      default:      return 8'h3F;
    endcase
  endfunction

  assign w_cw      = r_sync[1];
  assign w_fall    = r_cw_d & ~w_cw;
  assign w_acc     = w_fall & (r_mark >= C_GL);
  assign w_rx_dot  = w_acc & (r_mark < C_DOT);
  assign w_rx_dash = w_acc & (r_mark >= C_DOT);
  // a rejected glitch counts as space, so the gap timer carries on from where it was
  assign w_quiet   = ~w_cw & ~w_acc;
  assign w_rx_char = w_quiet & (r_space == C_CH);
  assign w_rx_word = w_quiet & (r_space == C_WD);
  assign w_man     = ~(w_rx_dot | w_rx_dash | w_rx_char | w_rx_word);
  assign w_ev_word = w_rx_word | (w_man & word_space_inp);
  assign w_ev_char = w_rx_char | (w_man & ~word_space_inp & char_space_inp);
  assign w_ev_dash = w_rx_dash | (w_man & ~word_space_inp & ~char_space_inp & dash_inp);
  assign w_ev_dot  = w_rx_dot | (w_man & ~word_space_inp & ~char_space_inp & ~dash_inp & dot_inp);
  assign w_sym     = w_ev_dot | w_ev_dash;

  assign w_bad  = r_too_long | (r_cnt > NW'(5)) | ((r_pat >> 5) != '0);
  assign w_code = w_bad ? 8'h3F : f_decode({r_cnt[2:0], r_pat[4:0]});

  assign w_last_sp  = w_push ? (w_push_data == 8'h20) : r_last_sp;
  assign w_any      = w_push | r_any;
  assign w_take     = (r_state != EMIT_CHAR) | ~r_sp_pend;
  assign w_char_go  = w_take & (w_ev_char | w_ev_word) & (r_cnt != '0);
  assign w_space_go = w_take & w_ev_word & (r_cnt == '0) & w_any & ~w_last_sp;

  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;

  always_comb
    w_next = w_char_go ? EMIT_CHAR :
             w_space_go ? EMIT_SPACE :
             (r_state == EMIT_CHAR && r_sp_pend) ? EMIT_SPACE : IDLE;

  always_comb begin
    w_push      = r_state != IDLE;
    w_push_data = r_state == EMIT_CHAR ? r_code : 8'h20;
  end

  assign w_valid = r_level != '0;
  assign w_pop   = w_valid & m_out.out_ready;
  assign w_full  = r_level == (AW+1)'(FIFO_DEPTH);
  assign w_wr    = w_push & (~w_full | w_pop);

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_sync     <= '0;
      r_cw_d     <= 1'b0;
      r_mark     <= '0;
      r_space    <= '0;
      r_pat      <= '0;
      r_cnt      <= '0;
      r_too_long <= 1'b0;
      r_code     <= '0;
      r_sp_pend  <= 1'b0;
      r_any      <= 1'b0;
      r_last_sp  <= 1'b0;
      r_rd       <= '0;
      r_wr       <= '0;
      r_level    <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_sync    <= {r_sync[0], rx_cw};
      r_cw_d    <= w_cw;
      r_mark    <= w_cw ? (r_mark == C_SAT ? r_mark : r_mark + CW'(1)) : '0;
      r_space   <= w_cw ? r_space : w_acc ? '0 : (r_space == C_SAT ? r_space : r_space + CW'(1));
      r_sp_pend <= w_char_go & w_ev_word;
      r_any     <= w_any;
      r_last_sp <= w_last_sp;
      if (w_char_go) begin
        r_code     <= w_code;
        r_pat      <= '0;
        r_cnt      <= '0;
        r_too_long <= 1'b0;
      end else if (w_sym) begin
        if (r_cnt == NW'(MAX_SYMS)) r_too_long <= 1'b1;
        else begin
          r_pat <= {r_pat[MAX_SYMS-2:0], w_ev_dash};
          r_cnt <= r_cnt + NW'(1);
        end
      end
      if (w_wr) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_level <= r_level + (AW+1)'(w_wr) - (AW+1)'(w_pop);
      if (w_push & w_full & ~w_pop) r_ovf <= 1'b1;
    end

  always_ff @(posedge clk)
    if (w_wr) r_mem[r_wr] <= w_push_data;

  assign m_out.out_valid = w_valid;
  assign m_out.out_data  = w_valid ? r_mem[r_rd] : 8'h00;
  assign fifo_level      = r_level;
  assign overflow        = r_ovf;
  assign busy            = (r_cnt != '0) | (r_state != IDLE);
endmodule

// File: tb/tb_morse_stream_decoder.sv
// tb_morse_stream_decoder: vector table + scoreboard bench for the Morse decoder (UNIT=16, FIFO_DEPTH=4)
module tb_morse_stream_decoder;
  logic clk = 1'b0, rst = 1'b0, rx_cw = 1'b0;
  logic dot_i = 1'b0, dash_i = 1'b0, cs_i = 1'b0, ws_i = 1'b0;
  logic [2:0] level;
  logic ovf, busy;
  int n_cmp = 0, n_err = 0;
  logic [7:0] q[$];

  typedef struct {
    int         n;
    logic [15:0] s;
    logic [7:0]  e;
  } vec_t;
  vec_t vt [13];

  morse_stream_decoder_if bus();

  morse_stream_decoder #(
    .UNIT_CYCLES(16), .GLITCH_CYCLES(4), .MAX_SYMS(6), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .rx_cw(rx_cw),
    .dot_inp(dot_i), .dash_inp(dash_i), .char_space_inp(cs_i), .word_space_inp(ws_i),
    .m_out(bus), .fifo_level(level), .overflow(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk)
    if (rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL pop_unexpected: got %02h want no output", bus.out_data);
      end else chk("pop_data", bus.out_data, q.pop_front());
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic d, input logic a, input logic c, input logic w);
    {dot_i, dash_i, cs_i, ws_i} = {d, a, c, w};
    tick();
    {dot_i, dash_i, cs_i, ws_i} = 4'b0;
  endtask

  task automatic rx_level(input logic v, input int n);
    rx_cw = v;
    repeat (n) tick();
  endtask

  task automatic send(input int n, input logic [15:0] s);
    for (int k = n - 1; k >= 0; k--) pulse(~s[k], s[k], 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic drain(input string nm);
    int k = 0;
    bus.out_ready = 1'b1;
    while ((q.size() != 0 || bus.out_valid) && k < 300) begin
      tick();
      k++;
    end
    chk({nm, "_left"}, q.size(), 0);
    chk({nm, "_level"}, level, 0);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{5, 16'b11111,   8'h30};
    vt[1]  = '{7, 16'b0000000, 8'h3F};
    vt[2]  = '{1, 16'b0,       8'h45};
    vt[3]  = '{1, 16'b1,       8'h54};
    vt[4]  = '{2, 16'b01,      8'h41};
    vt[5]  = '{4, 16'b1100,    8'h5A};
    vt[6]  = '{5, 16'b11110,   8'h39};
    vt[7]  = '{4, 16'b1101,    8'h51};
    vt[8]  = '{5, 16'b00000,   8'h35};
    vt[9]  = '{5, 16'b01010,   8'h3F};
    vt[10] = '{6, 16'b111111,  8'h3F};
    vt[11] = '{4, 16'b1011,    8'h59};
    vt[12] = '{3, 16'b100,     8'h44};
    bus.out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_data", bus.out_data, 8'h00);
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_level", level, 0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b1;
    tick();

    // rx 'A': dot, dash, gap shorter than a word
    rx_level(1'b1, 16);
    rx_level(1'b0, 16);
    rx_level(1'b1, 48);
    rx_level(1'b0, 60);
    chk("rxA_level", level, 1);
    chk("rxA_data", bus.out_data, 8'h41);
    rx_level(1'b0, 80);
    chk("rxA_word_level", level, 2);
    q.push_back(8'h41);
    q.push_back(8'h20);
    drain("rxA");

    // glitch inside a space must neither add a symbol nor restart the gap timer
    rx_level(1'b1, 16);
    rx_level(1'b0, 16);
    rx_level(1'b1, 2);
    rx_level(1'b0, 26);
    chk("glitch_early_level", level, 0);
    rx_level(1'b0, 18);
    chk("glitch_level", level, 1);
    chk("glitch_data", bus.out_data, 8'h45);
    rx_level(1'b0, 80);
    chk("glitch_word_level", level, 2);
    q.push_back(8'h45);
    q.push_back(8'h20);
    drain("glitch");

    // manual 'C' with exact emit latency, then word spaces
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    chk("c_busy", busy, 1'b1);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    chk("c_valid_n1", bus.out_valid, 1'b0);
    tick();
    chk("c_valid_n2", bus.out_valid, 1'b1);
    chk("c_data_n2", bus.out_data, 8'h43);
    chk("c_busy_idle", busy, 1'b0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) tick();
    chk("ws1_level", level, 2);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) tick();
    chk("ws2_level", level, 2);
    q.push_back(8'h43);
    q.push_back(8'h20);
    drain("c");

    bus.out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      send(vt[i].n, vt[i].s);
      q.push_back(vt[i].e);
      tick();
    end
    drain("table");

    // strobe priority: dash over dot, char over dot, word over char
    bus.out_ready = 1'b1;
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    q.push_back(8'h54);
    tick();
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b1, 1'b0);
    q.push_back(8'h45);
    tick();
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b1);
    q.push_back(8'h45);
    q.push_back(8'h20);
    drain("prio");

    // overflow: fifth character is dropped
    send(1, 16'b0);   tick();
    send(1, 16'b1);   tick();
    send(2, 16'b00);  tick();
    send(2, 16'b11);  tick();
    send(3, 16'b000); repeat (3) tick();
    chk("ovf_level", level, 4);
    chk("ovf_flag", ovf, 1'b1);
    chk("ovf_head", bus.out_data, 8'h45);
    q.push_back(8'h45);
    q.push_back(8'h54);
    q.push_back(8'h49);
    q.push_back(8'h4D);
    drain("ovf");
    chk("ovf_sticky", ovf, 1'b1);

    // reset mid-mark with a buffered char and two pending symbols
    send(1, 16'b0);
    repeat (2) tick();
    chk("pre_rst_level", level, 1);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    rx_level(1'b1, 8);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_valid", bus.out_valid, 1'b0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_ovf", ovf, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_data", bus.out_data, 8'h00);
    q.delete();
    rx_cw = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rx_level(1'b1, 16);
    rx_level(1'b0, 60);
    chk("post_rst_level", level, 1);
    chk("post_rst_data", bus.out_data, 8'h45);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/morse_stream_decoder.md
# morse_stream_decoder

Parametrised next-generation Morse receive path: classifies a keyed CW level, or manual symbol strobes, into dots, dashes, character gaps and word gaps. It decodes completed characters to ASCII and buffers them in a FIFO with a valid/ready output. It replaces the fixed 3-bit symbol → serial byte chain with configurable timing, glitch filtering, A–Z/0–9 decoding, word-space insertion and back-pressure.

## Interface
- UNIT_CYCLES, 1000: clock cycles per Morse time unit (one dot); legal values ≥ 8.
- GLITCH_CYCLES, 4: marks shorter than this are discarded; must be < UNIT_CYCLES/2.
- MAX_SYMS, 6: symbol register depth; legal values ≥ 5.
- FIFO_DEPTH, 8: output buffer entries; power of 2, ≥ 2.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset; all state cleared while low.
- rx_cw  in  1  asynchronous keyed level; 1 = mark (tone on).
- dot_inp, dash_inp, char_space_inp, word_space_inp  in  1 each  manual single-cycle strobes, synchronous to clk.
- out_data  out  8  ASCII character at FIFO head.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts out_data when out_valid & out_ready.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  entries held.
- overflow  out  1  sticky; set when a character is dropped on full FIFO.
- busy  out  1  symbols pending or emit FSM not IDLE.

## Operation
- rx_cw passes through a 2-flop synchroniser. Mark and space counters count synchronised high and low cycles, saturating at 8*UNIT_CYCLES.
- Mark end (falling edge): length < GLITCH_CYCLES → ignored, and the space counter resumes from its previous value. Length < 2*UNIT_CYCLES → dot event. Otherwise → dash event.
- Space: when the counter reaches 3*UNIT_CYCLES, one char_end event fires. When it reaches 7*UNIT_CYCLES, one word_end event fires. Each fires once per gap. The counter resets on the next accepted mark.
- Symbol register: pattern[MAX_SYMS-1:0] with dot=0 and dash=1, shifted in at the LSB, plus a count. A symbol beyond MAX_SYMS sets an internal too_long flag; the pattern is frozen.
- Event priority in one cycle: rx-derived event first. A manual strobe arriving in the same cycle is dropped. Among manual strobes: word_space > char_space > dash > dot.
- Decode, keyed by (count, pattern):
  - A–Z (1–4 symbols) → 0x41–0x5A.
  - 0–9 (5 symbols) → 0x30–0x39.
  - Any other pattern, too_long set, or count > 5 → '?' (0x3F).
- Emit FSM states: IDLE, EMIT_CHAR, EMIT_SPACE.
  - char_end with count>0 → code latched; symbol register cleared in the same cycle; → EMIT_CHAR.
  - char_end with count=0 → no action.
  - word_end: if count>0 → EMIT_CHAR then EMIT_SPACE. Else → EMIT_SPACE, unless the last character pushed since reset was 0x20 or nothing has been pushed.
  - EMIT_CHAR pushes the latched code, then goes to EMIT_SPACE if a space is pending, else IDLE.
  - EMIT_SPACE pushes 0x20 → IDLE.
  - Symbols arriving while the FSM is in EMIT_* accumulate normally into the cleared register.
- FIFO:
  - Push on full with no pop in that cycle → character dropped and overflow set. overflow clears only on reset.
  - Push and pop in the same cycle on full → both succeed; level unchanged.
  - Pop on empty → ignored.
- out_data is held stable while out_valid & !out_ready.

## Timing
- Reset values: out_data=0x00, out_valid=0, fifo_level=0, overflow=0, busy=0. FSM=IDLE, counters=0, symbol register empty, last-pushed marker = "none".
- Reset asserted mid-character or mid-emit discards all pending symbols and buffered characters.
- rx_cw path latency: 2 cycles of synchronisation, then the classification event fires in the cycle after the synchronised falling edge.
- Manual strobe in cycle N: symbol register updated at edge N+1.
- char_end event in cycle N: EMIT_CHAR during N+1; FIFO write at edge N+2; out_valid=1 in N+2 if the FIFO was empty.
- Word space character follows 1 cycle after its preceding character.
- Pop: out_valid & out_ready in cycle N → next entry, or out_valid=0, from N+1.
- Throughput: 1 push and 1 pop per cycle.

## Test plan
- UNIT_CYCLES=16. rx_cw: mark 16, space 16, mark 48, then space ≥ 48 → one entry 0x41 ('A'); fifo_level=1; no space character.
- Manual strobes dash, dot, dash, dot, then char_space → 0x43 ('C') at out_data 2 cycles after char_space. Then word_space → 0x20 pushed; a second word_space pushes nothing.
- Manual input of 5 dashes then char_space → 0x30 ('0'). 7 dots then char_space → 0x3F ('?').
- Glitch: mark of 2 cycles inside a 32-cycle space → no symbol, and char_end still fires at 48 total space cycles.
- FIFO_DEPTH=4 with out_ready=0: push 5 characters → fifo_level=4, overflow=1, 5th character lost. Then out_ready=1 → characters 1–4 come out in order.
- Assert rst low mid-way through an rx_cw mark with 2 symbols pending → all outputs return to reset values immediately. After release, a clean 'E' (single dot) decodes as 0x45.
